// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder sequencer: one full-adder cell, LSB first, carry recirculated.
// Optional subtract mode is enabled by defining SERIAL_SUB_EN (adds the `sub` port).

module add_1_bit (
  input  logic x,
  input  logic y,
  input  logic r,
  output logic z,
  output logic r1
);
  assign z  = x ^ y ^ r;
  assign r1 = (x & y) | (r & (x ^ y));
endmodule

module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] s_sr;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             z;
  logic             r1;
  logic [WIDTH-1:0] s_next;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;

  add_1_bit u_cell (
    .x  (a_sr[0]),
    .y  (b_sr[0]),
    .r  (carry),
    .z  (z),
    .r1 (r1)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB result.
  assign s_next = (s_sr >> 1) | {z, {(WIDTH-1){1'b0}}};

`ifdef SERIAL_SUB_EN
  // Subtract as a + ~b + 1; cout then reads as "no borrow".
  assign b_load     = sub ? ~b : b;
  assign carry_load = sub ? 1'b1 : cin;
`else
  assign b_load     = b;
  assign carry_load = cin;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      s_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b_load;
            s_sr  <= '0;
            carry <= carry_load;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          s_sr  <= s_next;
          carry <= r1;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            // Publish directly from the final cell output so done and sum align.
            busy  <= 1'b0;
            done  <= 1'b1;
            sum   <= s_next;
            cout  <= r1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
